// File: rtl/pc_block.sv
// Program counter for the single-cycle core: registers the next-PC every edge.
// Latency: in -> salida one rising clk edge; salida_plus4/misaligned combinational from salida.
// Backpressure: none; no stall or enable, so the PC is written on every edge.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-high reset, loads RESET_VALUE (wins over in)
//   in           next-PC value from the PC-select logic, stored verbatim
//   salida       current PC (register output only, glitch-free)
//   salida_plus4 salida + INC, carry-out discarded
//   misaligned   1 when any of the low ALIGN_BITS bits of salida is set
module pc_block #(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int                INC         = 4,
    parameter int                ALIGN_BITS  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] salida,
    output logic [WIDTH-1:0] salida_plus4,
    output logic             misaligned
);

    // Increment sized to the PC width so the add wraps modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    // No power-on value: salida stays X until the first reset edge, which
    // keeps a missing boot reset visible in simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            salida <= RESET_VALUE;
        end else begin
            salida <= in;
        end
    end

    assign salida_plus4 = salida + INC_W;

    // Low bits are only flagged, never masked; fetch logic decides what to do.
    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign misaligned = |salida[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_block.sv
// Testbench for pc_block: directed plan items followed by randomized load/reset traffic.
// Latency: expects in on salida one edge after sampling; derived outputs checked #1 after the edge.
// Backpressure: none; inputs change on the falling edge, outputs sampled away from the rising edge.
module tb_pc_block;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in;
    logic [31:0] salida;
    logic [31:0] salida_plus4;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    // Reference: the PC is simply "last value loaded", reset giving the boot vector.
    logic [31:0] ref_pc;
    bit          ref_valid = 1'b0;

    always #50 clk = ~clk;

    pc_block #(
        .WIDTH       (32),
        .RESET_VALUE (RST_PC),
        .INC         (4),
        .ALIGN_BITS  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .salida       (salida),
        .salida_plus4 (salida_plus4),
        .misaligned   (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_plus4(input logic [31:0] pc);
        longint unsigned s;
        s = (longint'(pc) + 4) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    function automatic logic [31:0] ref_misal(input logic [31:0] pc);
        return (pc % 4 != 0) ? 32'd1 : 32'd0;
    endfunction

    // One clock period: drive at the falling edge, confirm salida holds before
    // the rising edge, then check all outputs just after it.
    task automatic cycle(input string tag, input logic r, input logic [31:0] v);
        @(negedge clk);
        reset = r;
        in    = v;
        #1;
        if (ref_valid) check({tag, ".hold"}, salida, ref_pc);
        @(posedge clk);
        ref_pc    = r ? RST_PC : v;
        ref_valid = 1'b1;
        #1;
        check({tag, ".pc"},    salida,             ref_pc);
        check({tag, ".plus4"}, salida_plus4,       ref_plus4(ref_pc));
        check({tag, ".misal"}, 32'(misaligned),    ref_misal(ref_pc));
    endtask

    initial begin
        reset = 1'b0;
        in    = 32'h0;

        // 1. reset ignores in
        cycle("reset", 1'b1, 32'h0000_0100);
        check("reset.pc_const",    salida,          32'h0000_0000);
        check("reset.plus4_const", salida_plus4,    32'h0000_0004);
        check("reset.misal_const", 32'(misaligned), 32'd0);

        // 2. steady load over three periods
        for (int i = 0; i < 3; i++) cycle("steady", 1'b0, 32'h0000_0004);
        check("steady.plus4_const", salida_plus4, 32'h0000_0008);

        // 3. sequence, one-edge latency
        for (int i = 0; i < 4; i++) cycle("seq", 1'b0, 32'(i * 4));
        check("seq.last", salida, 32'h0000_000C);

        // 4. large values and wrap
        cycle("large", 1'b0, 32'hC888_8888);
        check("large.plus4_const", salida_plus4, 32'hC888_888C);
        cycle("wrap", 1'b0, 32'hFFFF_FFFC);
        check("wrap.plus4_const", salida_plus4, 32'h0000_0000);

        // 5. misalignment flag sets and clears
        cycle("misal_set", 1'b0, 32'h0000_0006);
        check("misal_set.const", 32'(misaligned), 32'd1);
        cycle("misal_clr", 1'b0, 32'h0000_0008);
        check("misal_clr.const", 32'(misaligned), 32'd0);

        // 6. mid-run reset beats in, then normal loading resumes
        cycle("pre_rst", 1'b0, 32'h0000_0040);
        cycle("mid_rst", 1'b1, 32'h0000_0044);
        check("mid_rst.const", salida, 32'h0000_0000);
        cycle("post_rst", 1'b0, 32'h0000_0048);
        check("post_rst.const", salida, 32'h0000_0048);

        // Randomized traffic: mostly loads, occasional reset, mixed alignment.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] v;
            logic        r;
            v = $urandom;
            if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) v = 32'hFFFF_FFFC;
            r = ($urandom_range(0, 15) == 0);
            cycle("rand", r, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
